owm_avalon_master: RTL and testbench
====================================

Name: owm_avalon_master

Overview:
- Avalon-MM slave 1-Wire bus master: the 1-Wire peripheral instantiated inside the `owm_sys` interconnect.
- The CPU issues reset/presence, single-bit and byte commands. The block generates standard-speed 1-Wire slot timing from a 1 us tick.
- Drives `ow_o` into the board open-drain buffer (0 = pull line low, 1 = release) and samples the line on `ow_i`.

Parameters:
- `CLK_DIV`, 50, system clock cycles per 1 us timing tick; minimum 2.
- `SYNC_STAGES`, 2, flip-flop stages synchronising `ow_i`; minimum 2.

Ports:
- `clk_i` input 1 — system clock.
- `rst_i` input 1 — asynchronous, active-high reset.
- `avs_address` input 2 — word address.
- `avs_read` input 1 — read strobe.
- `avs_write` input 1 — write strobe.
- `avs_writedata` input 32 — write data.
- `avs_readdata` output 32 — read data, fixed latency 1.
- `irq_o` output 1 — level interrupt, command done.
- `ow_o` output 1 — 1-Wire drive: 0 = low, 1 = release.
- `ow_i` input 1 — 1-Wire line state (asynchronous).

Behaviour:
- **Reset values:** `ow_o`=1, `avs_readdata`=0, `irq_o`=0. All registers 0; FSM in `IDLE`.
- **Reset mid-command:** asserting `rst_i` aborts any command and releases the line immediately (asynchronous, not on the next edge).
- **Register map:**
  - addr 0 CTRL/STAT, write: bit0 RST_CMD, bit1 BIT_CMD, bit2 BYTE_CMD, bit8 BIT_VAL (value for BIT_CMD), bit16 IE.
  - addr 0 CTRL/STAT, read: bit0 BUSY, bit1 PRESENCE, bit2 DONE, bit8 last sampled bit, bit16 IE.
  - addr 1 DATA: write bits[7:0] = TX byte; read bits[7:0] = RX byte.
  - addr 2 DIVIDER: read-only, returns `CLK_DIV`.
  - addr 3: reads 0; writes ignored.
- **Readdata:** registered; valid on the cycle after `avs_read`. Unused bits read 0. No waitrequest.
- **Command acceptance:** only while BUSY=0; command writes while BUSY=1 are ignored. The IE bit is always written.
- **Command priority:** if several command bits are set, RST > BYTE > BIT.
- **On accept:**
  - BUSY=1 and DONE=0 on the next cycle.
  - The prescaler restarts at 0, so the first tick arrives `CLK_DIV` cycles later.
- **DONE:**
  - Set to 1 in the same cycle BUSY returns to 0.
  - Cleared by a read of addr 0; the clearing read returns DONE=1.
  - Also cleared by accepting a new command.
  - If a read of addr 0 and the DONE-set event coincide, the set wins.
- **Timing tick:** the prescaler counts 0..`CLK_DIV`-1 and pulses the tick at `CLK_DIV`-1. The phase timer counts ticks (t, in us).
- **FSM states:** `IDLE`, `RST_LOW`, `RST_REL`, `SLOT_LOW`, `SLOT_REL`, `FINISH`.
- **RST_CMD:**
  - `RST_LOW`: `ow_o`=0 for 480 us.
  - `RST_REL`: release; sample the line at t=70. PRESENCE = inverse of the sampled value. End at t=480.
  - Total 960 us, then `FINISH`.
- **Slot:**
  - Slot start: `SLOT_LOW` drives `ow_o`=0, for 6 us if the bit is 1 or 60 us if the bit is 0.
  - `SLOT_REL`: release, hold until 70 us from slot start, then a 10 us recovery (slot total 80 us).
  - The line is sampled at t=15 from slot start into "last bit".
- **Byte command:** BIT_CMD performs one slot using BIT_VAL. BYTE_CMD performs 8 slots, LSB first, on the latched TX byte; the sampled bits shift into RX from the MSB side. Read a byte by writing TX=0xFF.
- **FINISH:** one cycle; sets DONE, clears BUSY, returns to `IDLE`.
- **Sampling:** uses the `SYNC_STAGES`-synchronised `ow_i`. Sample points land within +/-1 tick.
- **DATA writes:** a write while BUSY=1 updates the TX register but does not affect the byte in flight (latched at accept).

Optional Feature:
- Macro: `OWM_IRQ_EN`.
- **Defined:** `irq_o` = DONE & IE, registered, deasserting the cycle after DONE clears.
- **Undefined:** `irq_o` is tied to 0; IE still reads back as written.

Test Plan:
- Reset/presence, with `CLK_DIV`=50 and an emulated slave pulling `ow_i` low from t=500 to 620 us:
  - `ow_o` is low for exactly 24000 cycles.
  - BUSY clears after 48000 cycles (plus accept/FINISH overhead).
  - Read addr 0 returns PRESENCE=1, DONE=1; a second read returns DONE=0.
- Reset with no slave (`ow_i`=1) -> PRESENCE=0, DONE=1.
- BYTE_CMD with TX=0xA5 and no slave:
  - Low pulses follow the LSB-first pattern 1,0,1,0,0,1,0,1 with widths 300/3000/300/3000/3000/300/3000/300 cycles.
  - Slot spacing is 4000 cycles; RX=0xA5 (lines read back as driven).
- BYTE_CMD with TX=0xFF while the slave holds `ow_i` low through the sample point on bits 1 and 3 -> RX=0xF5.
- BIT_CMD written while BUSY=1 is ignored: no extra slot, RX unchanged. RST_CMD|BYTE_CMD written together performs a reset only.
- `rst_i` pulsed during `RST_LOW` -> `ow_o`=1 within the same cycle; all status 0. With `OWM_IRQ_EN`: IE=1 and a completed command give `irq_o`=1 until addr 0 is read.

Source files
------------

// File: rtl/owm_avalon_master_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : owm_avalon_master_if
//  Purpose  : Avalon-MM register-port bundle for the 1-Wire bus master.
//             The CPU side uses the master modport; the peripheral uses slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface owm_avalon_master_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );
endinterface
`default_nettype wire

// File: rtl/owm_avalon_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : owm_avalon_master
//  Purpose  : Avalon-MM slave 1-Wire bus master. Generates standard-speed
//             reset/presence and read/write slots from a 1 us tick and drives
//             an open-drain buffer (ow_o: 0 = pull low, 1 = release).
//  Options  : OWM_IRQ_EN - when defined, irq_o = DONE & IE (registered);
//             otherwise irq_o is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module owm_avalon_master #(
  parameter int CLK_DIV     = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  owm_avalon_master_if.slave        avs,
  output logic                      irq_o,
  output logic                      ow_o,
  input  logic                      ow_i
);

  localparam int                     c_presc_w    = $clog2(CLK_DIV);
  localparam logic [c_presc_w-1:0]   c_presc_last = c_presc_w'(CLK_DIV - 1);

  // Phase-timer compare points: the action for time t fires on the tick
  // that advances the timer from t-1 to t.
  localparam logic [8:0] c_t_reset_last = 9'd479;  // 480 us low / release
  localparam logic [8:0] c_t_presence   = 9'd69;   // presence sample at 70 us
  localparam logic [8:0] c_t_low1       = 9'd5;    // 6 us low for a 1 bit
  localparam logic [8:0] c_t_low0       = 9'd59;   // 60 us low for a 0 bit
  localparam logic [8:0] c_t_sample     = 9'd14;   // slot sample at 15 us
  localparam logic [8:0] c_t_slot_last  = 9'd79;   // 70 us + 10 us recovery

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_LOW  = 3'd1,
    RST_REL  = 3'd2,
    SLOT_LOW = 3'd3,
    SLOT_REL = 3'd4,
    FINISH   = 3'd5
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_presc_w-1:0]   r_presc;
  logic [8:0]             r_t;
  logic                   r_ow;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_presence;
  logic                   r_last_bit;
  logic                   r_ie;
  logic [7:0]             r_tx;
  logic [7:0]             r_rx;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitcnt;
  logic                   r_byte_mode;
  logic [31:0]            r_readdata;

  logic        w_ow_sync;
  logic        w_tick;
  logic        w_wr_ctrl;
  logic        w_rd_ctrl;
  logic        w_accept;
  logic        w_slot_sample;
  logic [8:0]  w_low_last;
  logic [31:0] w_wd;
  logic        w_unused_wd;

  assign w_wd          = avs.avs_writedata;
  assign w_ow_sync     = r_sync[SYNC_STAGES-1];
  assign w_tick        = (r_presc == c_presc_last);
  assign w_wr_ctrl     = avs.avs_write && (avs.avs_address == 2'd0);
  assign w_rd_ctrl     = avs.avs_read  && (avs.avs_address == 2'd0);
  assign w_accept      = w_wr_ctrl && (|w_wd[2:0]) && !r_busy;
  assign w_slot_sample = w_tick && (r_t == c_t_sample) &&
                         ((r_state == SLOT_LOW) || (r_state == SLOT_REL));
  assign w_low_last    = r_shift[0] ? c_t_low1 : c_t_low0;
  assign w_unused_wd   = ^{w_wd[31:17], w_wd[15:9], w_wd[7:3]};

  assign ow_o             = r_ow;
  assign avs.avs_readdata = r_readdata;

  // Bring the asynchronous line state into the clock domain (idle level high).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], ow_i};
  end

  // 1 us prescaler; restarts on command accept so the first tick is CLK_DIV cycles out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   r_presc <= '0;
    else if (w_accept || w_tick) r_presc <= '0;
    else                         r_presc <= r_presc + 1'b1;
  end

  // IE is writable at any time; TX may change mid-byte since the byte is latched at accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ie <= 1'b0;
      r_tx <= 8'd0;
    end else begin
      if (w_wr_ctrl) r_ie <= w_wd[16];
      if (avs.avs_write && (avs.avs_address == 2'd1)) r_tx <= w_wd[7:0];
    end
  end

  // Command sequencer: slot/reset timing, line drive, sampling and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ow        <= 1'b1;
      r_t         <= 9'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_presence  <= 1'b0;
      r_last_bit  <= 1'b0;
      r_rx        <= 8'd0;
      r_shift     <= 8'd0;
      r_bitcnt    <= 3'd0;
      r_byte_mode <= 1'b0;
    end else begin
      // Read-to-clear; a later assignment in FINISH overrides, so set wins.
      if (w_rd_ctrl) r_done <= 1'b0;

      if (w_slot_sample) begin
        r_last_bit <= w_ow_sync;
        if (r_byte_mode) r_rx <= {w_ow_sync, r_rx[7:1]};
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_t    <= 9'd0;
            r_ow   <= 1'b0;
            if (w_wd[0]) begin
              r_state <= RST_LOW;
            end else if (w_wd[2]) begin
              r_state     <= SLOT_LOW;
              r_shift     <= r_tx;
              r_bitcnt    <= 3'd7;
              r_byte_mode <= 1'b1;
            end else begin
              r_state     <= SLOT_LOW;
              r_shift     <= {7'd0, w_wd[8]};
              r_bitcnt    <= 3'd0;
              r_byte_mode <= 1'b0;
            end
          end
        end

        RST_LOW: begin
          if (w_tick) begin
            if (r_t == c_t_reset_last) begin
              r_state <= RST_REL;
              r_ow    <= 1'b1;
              r_t     <= 9'd0;
            end else begin
              r_t <= r_t + 9'd1;
            end
          end
        end

        RST_REL: begin
          if (w_tick) begin
            if (r_t == c_t_presence) r_presence <= ~w_ow_sync;
            if (r_t == c_t_reset_last) begin
              r_state <= FINISH;
              r_t     <= 9'd0;
            end else begin
              r_t <= r_t + 9'd1;
            end
          end
        end

        SLOT_LOW: begin
          if (w_tick) begin
            r_t <= r_t + 9'd1;
            if (r_t == w_low_last) begin
              r_state <= SLOT_REL;
              r_ow    <= 1'b1;
            end
          end
        end

        SLOT_REL: begin
          if (w_tick) begin
            if (r_t == c_t_slot_last) begin
              r_t <= 9'd0;
              if (r_bitcnt == 3'd0) begin
                r_state <= FINISH;
              end else begin
                r_state  <= SLOT_LOW;
                r_ow     <= 1'b0;
                r_bitcnt <= r_bitcnt - 3'd1;
                r_shift  <= {1'b0, r_shift[7:1]};
              end
            end else begin
              r_t <= r_t + 9'd1;
            end
          end
        end

        FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          r_ow    <= 1'b1;
        end
      endcase
    end
  end

  // Fixed-latency-1 register read mux; idle cycles return 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_readdata <= 32'd0;
    end else if (avs.avs_read) begin
      case (avs.avs_address)
        2'd0:    r_readdata <= {15'd0, r_ie, 7'd0, r_last_bit, 5'd0,
                                r_done, r_presence, r_busy};
        2'd1:    r_readdata <= {24'd0, r_rx};
        2'd2:    r_readdata <= 32'(CLK_DIV);
        default: r_readdata <= 32'd0;
      endcase
    end else begin
      r_readdata <= 32'd0;
    end
  end

`ifdef OWM_IRQ_EN
  logic r_irq;

  // Level interrupt follows DONE & IE one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_irq <= 1'b0;
    else       r_irq <= r_done & r_ie;
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_owm_avalon_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_owm_avalon_master
//  Purpose  : Self-checking bench for owm_avalon_master with an emulated
//             1-Wire slave, a pulse monitor and a bit-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_owm_avalon_master;
  localparam int CDIV = 10;
  localparam int US   = CDIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic ow_o;
  logic ow_i;
  logic slave_pull = 1'b0;

  owm_avalon_master_if bus ();

  owm_avalon_master #(.CLK_DIV(CDIV), .SYNC_STAGES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .avs   (bus),
    .irq_o (irq),
    .ow_o  (ow_o),
    .ow_i  (ow_i)
  );

  // Open-drain wired-AND of master and emulated slave.
  assign ow_i = ow_o & ~slave_pull;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int low_cnt = 0;
  int q_start[$];
  int q_width[$];

  int         slave_mode = 0;   // 0 none, 1 presence pulse, 2 per-slot pulls
  logic [7:0] pull_mask  = 8'd0;
  int         slot_idx   = 0;

  typedef struct {
    logic       is_byte;
    logic [7:0] tx;
    logic [7:0] pull;
    logic [7:0] exp_rx;
    logic       exp_last;
  } vec_t;

  vec_t vecs[6];

  // Pulse monitor: records start cycle and width of each low pulse on ow_o.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        low_cnt = 0;
      end else if (ow_o === 1'b0) begin
        if (low_cnt == 0) q_start.push_back(cyc);
        low_cnt++;
      end else if (low_cnt != 0) begin
        q_width.push_back(low_cnt);
        low_cnt = 0;
      end
    end
  end

  // Emulated slave, triggered by each falling edge of the master drive.
  initial begin
    forever begin
      @(negedge ow_o);
      if (slave_mode == 1) begin
        repeat (500 * US) @(posedge clk);
        slave_pull = 1'b1;
        repeat (120 * US) @(posedge clk);
        slave_pull = 1'b0;
      end else if (slave_mode == 2) begin
        if (slot_idx < 8 && pull_mask[slot_idx]) begin
          repeat (10 * US) @(posedge clk);
          slave_pull = 1'b1;
          repeat (30 * US) @(posedge clk);
          slave_pull = 1'b0;
        end
        slot_idx++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    data = bus.avs_readdata;
  endtask

  // Poll status until BUSY drops; the returned word is the clearing read.
  task automatic wait_idle(input int t0, output logic [31:0] st, output int el);
    st = 32'h1;
    while (st[0] && (cyc - t0) < 12000) bus_read(2'd0, st);
    el = cyc - t0;
    if (st[0]) check("busy_timeout", st, 32'h0);
  endtask

  task automatic start_cmd(input logic [31:0] ctrl, input int mode, input logic [7:0] mask,
                           output int t0);
    q_start.delete();
    q_width.delete();
    slave_mode = mode;
    pull_mask  = mask;
    slot_idx   = 0;
    t0 = cyc;
    bus_write(2'd0, ctrl);
  endtask

  // Reference model: a slot reads 1 only if the master released early (bit 1)
  // and the slave did not hold the line through the sample point.
  function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic [7:0] pull);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tx[i] && !pull[i];
    return r;
  endfunction

  // Check pulse count, per-slot low widths and 80 us slot spacing.
  task automatic check_slots(input string tag, input logic [7:0] bits, input int n);
    check({tag, "_nslots"}, q_width.size(), n);
    for (int i = 0; i < n && i < q_width.size(); i++) begin
      check({tag, "_width"}, q_width[i], bits[i] ? 6 * US : 60 * US);
      if (i > 0) check({tag, "_spacing"}, q_start[i] - q_start[i-1], 80 * US);
    end
  endtask

  logic [31:0] rd;
  logic [31:0] st;
  logic [7:0]  rx_now;
  int          t0;
  int          el;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h00, 8'hA5, 1'b1};
    vecs[1] = '{1'b1, 8'hFF, 8'h0A, 8'hF5, 1'b1};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 8'h01, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 8'h01, 8'h01, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};

    bus.avs_address   = 2'd0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ow_o", ow_o, 1'b1);
    check("rst_readdata", bus.avs_readdata, 32'd0);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;
    bus_read(2'd0, rd);  check("rst_stat", rd, 32'd0);
    bus_read(2'd1, rd);  check("rst_data", rd, 32'd0);
    bus_read(2'd2, rd);  check("divider", rd, 32'(CDIV));
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);  check("addr3", rd, 32'd0);

    // Reset/presence with a responding slave
    start_cmd(32'h1, 1, 8'h00, t0);
    wait_idle(t0, st, el);
    check("pres_nlow", q_width.size(), 1);
    if (q_width.size() > 0) check("pres_low_width", q_width[0], 480 * US);
    check_range("pres_busy_cycles", el, 960 * US + 2, 960 * US + 6);
    check("pres_stat1", st[2:0], 3'b110);
    bus_read(2'd0, rd);
    check("pres_stat2", rd[2:0], 3'b010);

    // Reset with RST|BYTE together and no slave: reset only, no presence
    bus_read(2'd1, rd);  rx_now = rd[7:0];
    start_cmd(32'h5, 0, 8'h00, t0);
    wait_idle(t0, st, el);
    check("prio_nlow", q_width.size(), 1);
    if (q_width.size() > 0) check("prio_low_width", q_width[0], 480 * US);
    check("prio_stat", st[2:0], 3'b100);
    bus_read(2'd1, rd);  check("prio_rx_kept", rd[7:0], rx_now);

    // Table-driven slot vectors
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].is_byte) begin
        bus_write(2'd1, {24'd0, vecs[v].tx});
        start_cmd(32'h4, 2, vecs[v].pull, t0);
        wait_idle(t0, st, el);
        check_slots("vec_byte", vecs[v].tx, 8);
      end else begin
        start_cmd({23'd0, vecs[v].tx[0], 8'h02}, 2, vecs[v].pull, t0);
        wait_idle(t0, st, el);
        check_slots("vec_bit", vecs[v].tx, 1);
      end
      check("vec_done", st[2], 1'b1);
      check("vec_last", st[8], vecs[v].exp_last);
      bus_read(2'd1, rd);
      check("vec_rx", rd, {24'd0, vecs[v].exp_rx});
    end

    // Randomized bytes against the reference model
    for (int r = 0; r < 4; r++) begin
      logic [7:0] tx;
      logic [7:0] pm;
      logic [7:0] exp;
      tx  = 8'($urandom);
      pm  = 8'($urandom);
      exp = model_rx(tx, pm);
      bus_write(2'd1, {24'd0, tx});
      start_cmd(32'h4, 2, pm, t0);
      wait_idle(t0, st, el);
      check("rnd_nslots", q_width.size(), 8);
      check("rnd_last", st[8], exp[7]);
      bus_read(2'd1, rd);
      check("rnd_rx", rd, {24'd0, exp});
    end

    // Commands and DATA writes while busy do not disturb the byte in flight
    bus_write(2'd1, 32'h3C);
    start_cmd(32'h4, 0, 8'h00, t0);
    repeat (100) @(negedge clk);
    bus_write(2'd0, 32'h102);
    bus_write(2'd1, 32'h00);
    wait_idle(t0, st, el);
    check_slots("busy_ign", 8'h3C, 8);
    bus_read(2'd1, rd);
    check("busy_ign_rx", rd, 32'h3C);

    // IE readback and interrupt behaviour on completion
    bus_write(2'd0, 32'h1_0000);
    bus_read(2'd0, rd);
    check("ie_readback", rd[16], 1'b1);
    start_cmd(32'h1_0102, 0, 8'h00, t0);
    repeat (80 * US + 10) @(negedge clk);
`ifdef OWM_IRQ_EN
    check("irq_set", irq, 1'b1);
`else
    check("irq_tied", irq, 1'b0);
`endif
    bus_read(2'd0, rd);
    check("irq_stat", {rd[16], rd[2], rd[0]}, 3'b110);
    repeat (3) @(negedge clk);
    check("irq_clear", irq, 1'b0);

    // Asynchronous reset in the middle of RST_LOW
    start_cmd(32'h1_0001, 0, 8'h00, t0);
    repeat (50 * US) @(negedge clk);
    check("arst_low_before", ow_o, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_release", ow_o, 1'b1);
    check("arst_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(2'd0, rd);  check("arst_stat", rd, 32'd0);
    bus_read(2'd1, rd);  check("arst_rx", rd, 32'd0);
    repeat (100) @(negedge clk);
    check("arst_idle_line", ow_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
